// File: rtl/modbus_pkg.sv
// Shared Modbus RTU constants: FSM encodings, function/exception codes,
// CRC-16/MODBUS parameters and the inter-frame silence helper.
package modbus_pkg;

  localparam logic [1:0] ST_WAIT_GAP = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_RECV     = 2'd2;
  localparam logic [1:0] ST_CHECK    = 2'd3;

  localparam logic [7:0]  FUNC_RD_INPUT = 8'h04;
  localparam logic [7:0]  EXC_ILL_FUNC  = 8'h01;
  localparam logic [7:0]  EXC_ILL_VALUE = 8'h03;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  localparam logic [15:0] MAX_QTY = 16'd125;

  // 3.5 characters of 11 bits each, in clock cycles.
  function automatic int t35_cycles(input int clk_freq, input int baud_rate);
    return (clk_freq / baud_rate) * 77 / 2;
  endfunction

endpackage

// File: rtl/crc16_byte.sv
// Combinational CRC-16/MODBUS update for one byte, LSB first (reflected).
module crc16_byte
  import modbus_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] crc_work;

  always_comb begin
    crc_work = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      if (crc_work[0]) crc_work = (crc_work >> 1) ^ CRC_POLY;
      else             crc_work = crc_work >> 1;
    end
    crc_out = crc_work;
  end

endmodule

// File: rtl/rx_req_parser.sv
// Modbus RTU slave receive path: frames bytes by T3.5 silence, checks CRC and
// address, and decodes read-input-registers requests or exception replies.
module rx_req_parser
  import modbus_pkg::*;
#(
  parameter logic [7:0] SADDR     = 8'h01,
  parameter int         CLK_FREQ  = 50000000,
  parameter int         BAUD_RATE = 115200
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        req_valid,
  output logic [7:0]  func_code,
  output logic [15:0] start_addr,
  output logic [7:0]  tx_quantity,
  output logic        exc_valid,
  output logic [7:0]  exc_code
);

  localparam int T35   = t35_cycles(CLK_FREQ, BAUD_RATE);
  localparam int GAP_W = $clog2(T35 + 1);
  localparam logic [GAP_W-1:0] T35_V = GAP_W'(T35);

  logic [1:0]       state;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_done;
  logic [7:0]       frame_buf [8];
  logic [3:0]       byte_cnt;
  logic             overflow;
  logic [15:0]      crc;
  logic [15:0]      crc_next;
  logic [15:0]      qty;
  logic             frame_good;

  crc16_byte u_crc (
    .crc_in  (crc),
    .data    (rx_data),
    .crc_out (crc_next)
  );

  assign gap_done = (gap_cnt == T35_V);

  // A frame is only answered when complete, intact and addressed to us;
  // broadcasts never get a reply from this read-only slave.
  always_comb begin
    qty        = {frame_buf[4], frame_buf[5]};
    frame_good = (byte_cnt == 4'd8) && !overflow && (crc == 16'h0000) &&
                 (frame_buf[0] == SADDR) && (SADDR != 8'h00);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= ST_WAIT_GAP;
      gap_cnt     <= '0;
      byte_cnt    <= '0;
      overflow    <= 1'b0;
      crc         <= CRC_INIT;
      req_valid   <= 1'b0;
      exc_valid   <= 1'b0;
      exc_code    <= '0;
      func_code   <= '0;
      start_addr  <= '0;
      tx_quantity <= '0;
      for (int i = 0; i < 8; i++) frame_buf[i] <= '0;
    end else begin
      req_valid <= 1'b0;
      exc_valid <= 1'b0;

      if (rx_valid)      gap_cnt <= '0;
      else if (!gap_done) gap_cnt <= gap_cnt + 1'b1;

      case (state)
        ST_WAIT_GAP: begin
          crc      <= CRC_INIT;
          byte_cnt <= '0;
          overflow <= 1'b0;
          if (!rx_valid && gap_done) state <= ST_IDLE;
        end

        ST_IDLE: begin
          if (rx_valid) begin
            frame_buf[0] <= rx_data;
            byte_cnt     <= 4'd1;
            crc          <= crc_next;
            state        <= ST_RECV;
          end
        end

        // A byte arriving on the very cycle the silence completes still
        // belongs to this frame, so rx_valid is tested first.
        ST_RECV: begin
          if (rx_valid) begin
            if (byte_cnt == 4'd8) begin
              overflow <= 1'b1;
            end else begin
              frame_buf[byte_cnt[2:0]] <= rx_data;
              byte_cnt                 <= byte_cnt + 4'd1;
              crc                      <= crc_next;
            end
          end else if (gap_done) begin
            state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          state    <= ST_IDLE;
          crc      <= CRC_INIT;
          byte_cnt <= '0;
          overflow <= 1'b0;
          if (frame_good) begin
            func_code   <= frame_buf[1];
            start_addr  <= {frame_buf[2], frame_buf[3]};
            tx_quantity <= frame_buf[5];
            if (frame_buf[1] != FUNC_RD_INPUT) begin
              exc_valid <= 1'b1;
              exc_code  <= EXC_ILL_FUNC;
            end else if ((qty == 16'd0) || (qty > MAX_QTY)) begin
              exc_valid <= 1'b1;
              exc_code  <= EXC_ILL_VALUE;
            end else begin
              req_valid <= 1'b1;
            end
          end
        end

        default: state <= ST_WAIT_GAP;
      endcase
    end
  end

endmodule

// File: doc/rx_req_parser.md
RX_REQ_PARSER -- requirements
Module: rx_req_parser

Interface
REQ-001 Parameter SADDR, 8'h01, slave address this node answers.
REQ-002 Parameter CLK_FREQ, 'd50000000, clk_in frequency in Hz.
REQ-003 Parameter BAUD_RATE, 'd115200, line rate in baud.
REQ-004 clk_in  input  1  system clock; the block SHALL use this single clock domain only.
REQ-005 rst_n_in  input  1  system reset, asynchronous, active low.
REQ-006 rx_data  input  8  received byte from UART RX, valid only while rx_valid=1.
REQ-007 rx_valid  input  1  one-cycle strobe per received byte.
REQ-008 req_valid  output  1  one-cycle pulse: valid read-input-registers request decoded; drives tx_crc crc_start.
REQ-009 func_code  output  8  function code of the last accepted or rejected frame.
REQ-010 start_addr  output  16  register start address from the request.
REQ-011 tx_quantity  output  8  register count from the request (1..125).
REQ-012 exc_valid  output  1  one-cycle pulse: frame addressed to SADDR with good CRC but illegal content.
REQ-013 exc_code  output  8  Modbus exception code qualified by exc_valid.

Function
REQ-014 T35 SHALL equal (CLK_FREQ/BAUD_RATE)*77/2 cycles in integer arithmetic (3.5 chars x 11 bits); 16709 at default values.
REQ-015 A gap counter SHALL clear on every rx_valid cycle and otherwise increment, saturating at T35.
REQ-016 FSM states SHALL be WAIT_GAP, IDLE, RECV, CHECK, with transitions as in REQ-017 to REQ-020.
REQ-017 WAIT_GAP -> IDLE when the counter reaches T35; any rx_valid in WAIT_GAP restarts the wait.
REQ-018 IDLE -> RECV on rx_valid, storing that byte as byte 0.
REQ-019 RECV stores bytes 0..7 into an 8-byte buffer; a 9th and later byte SHALL set an overflow flag and not be stored.
REQ-020 RECV -> CHECK when the counter reaches T35; CHECK -> IDLE after one cycle.
REQ-021 rx_valid in the same cycle the counter reaches T35 SHALL win: the byte belongs to the current frame and the counter clears.
REQ-022 CRC-16/MODBUS SHALL be updated once per stored byte, in the rx_valid cycle: init 16'hFFFF, reflected polynomial 16'hA001.
REQ-023 CHECK SHALL drop the frame silently if count != 8, overflow is set, or the CRC over all 8 bytes (low CRC byte first) is not 16'h0000.
REQ-024 CHECK SHALL drop the frame silently if byte 0 != SADDR; broadcast address 0 SHALL be dropped.
REQ-025 If byte 1 != 8'h04, CHECK SHALL pulse exc_valid with exc_code 8'h01.
REQ-026 If quantity (bytes 4:5) is 0 or greater than 125, CHECK SHALL pulse exc_valid with exc_code 8'h03.
REQ-027 Otherwise CHECK SHALL pulse req_valid, with start_addr = {byte2, byte3} and tx_quantity = byte5.
REQ-028 req_valid/exc_valid SHALL be registered, asserting exactly T35+2 cycles after the final rx_valid.
REQ-029 func_code, start_addr and tx_quantity SHALL update only on the req_valid or exc_valid cycle and hold until the next one.
REQ-030 At most one of req_valid and exc_valid SHALL be high in any cycle.

Reset
REQ-031 Reset SHALL force all outputs to 0, clear buffer, byte count, overflow flag and gap counter, set CRC to 16'hFFFF, and enter WAIT_GAP.
REQ-032 Reset mid-frame SHALL discard the partial frame; no pulse SHALL follow reset release until a new full frame arrives.

Structure
REQ-033 Shared package modbus_pkg SHALL hold: FSM state encodings, FUNC_RD_INPUT=8'h04, EXC_ILL_FUNC=8'h01, EXC_ILL_VALUE=8'h03, CRC_INIT=16'hFFFF, CRC_POLY=16'hA001, MAX_QTY=125.
REQ-034 The byte-wise CRC update SHALL be a sub-module crc16_byte (inputs crc_in and data, output crc_out; combinational), reusable by tx_crc.

Verification
REQ-035 Bytes 01 04 00 00 00 04 F1 C9 at byte spacing, then silence -> one req_valid at T35+2 with start_addr=0000, tx_quantity=04, func_code=04.
REQ-036 Same frame with byte 7 = C8 -> no req_valid and no exc_valid.
REQ-037 01 03 00 00 00 04 44 09 -> exc_valid with exc_code=01 and func_code=03.
REQ-038 Address-1 frame with quantity 0 and bench-model CRC -> exc_valid with exc_code=03; the same frame to address 02 -> no pulse.
REQ-039 9-byte frame (valid frame plus trailing 00) -> dropped; a valid frame after T35 of silence -> req_valid.
REQ-040 rst_n_in low after byte 4 of a frame -> frame discarded; the next frame is accepted only after T35 of post-reset silence.
